// File: rtl/ln_cordic_iter_ctrl.sv
// Iteration sequencer for the ln hyperbolic CORDIC datapath.
// Define LN_CORDIC_REPEAT_ITER_EN to run indices 4 and 13 twice.
module ln_cordic_iter_ctrl #(
  parameter int W      = 5,
  parameter int N_ITER = 25
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         BEGIN,
  input  logic         ACK,
  input  logic [W-1:0] CNT_Y,
  output logic         CNT_EN,
  output logic         CNT_RST,
  output logic [W-1:0] ITER_IDX,
  output logic         LOAD_INIT,
  output logic         REG_EN,
  output logic         OUT_LOAD,
  output logic         READY,
  output logic         DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [W-1:0] LAST = W'(N_ITER - 1);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_term;
  logic   w_hold;

  assign ITER_IDX = CNT_Y;
  // Anything past the last index is a counter fault; finish anyway.
  assign w_term   = (CNT_Y >= LAST);

`ifdef LN_CORDIC_REPEAT_ITER_EN
  logic r_rep4;
  logic r_rep13;
  logic w_rep4_nxt;
  logic w_rep13_nxt;
  logic w_at4;
  logic w_at13;

  assign w_at4  = (N_ITER > 4) && (32'(CNT_Y) == 32'd4);
  assign w_at13 = (N_ITER > 13) && (32'(CNT_Y) == 32'd13);
  assign w_hold = (w_at4 && !r_rep4) || (w_at13 && !r_rep13);
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
`ifdef LN_CORDIC_REPEAT_ITER_EN
      r_rep4  <= 1'b0;
      r_rep13 <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
`ifdef LN_CORDIC_REPEAT_ITER_EN
      r_rep4  <= w_rep4_nxt;
      r_rep13 <= w_rep13_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    CNT_EN      = 1'b0;
    CNT_RST     = 1'b0;
    LOAD_INIT   = 1'b0;
    REG_EN      = 1'b0;
    OUT_LOAD    = 1'b0;
    READY       = 1'b0;
    DONE        = 1'b0;
`ifdef LN_CORDIC_REPEAT_ITER_EN
    w_rep4_nxt  = r_rep4;
    w_rep13_nxt = r_rep13;
`endif
    unique case (r_state)
      S_IDLE: begin
        READY   = 1'b1;
        CNT_RST = 1'b1;
        if (BEGIN) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        LOAD_INIT   = 1'b1;
        CNT_RST     = 1'b1;
`ifdef LN_CORDIC_REPEAT_ITER_EN
        w_rep4_nxt  = 1'b0;
        w_rep13_nxt = 1'b0;
`endif
        w_state_nxt = S_ITER;
      end
      S_ITER: begin
        REG_EN = 1'b1;
        if (w_hold) begin
          // First pass of a repeated index: keep counter still.
          CNT_EN = 1'b0;
`ifdef LN_CORDIC_REPEAT_ITER_EN
          if (w_at4 && !r_rep4) w_rep4_nxt = 1'b1;
          else                  w_rep13_nxt = 1'b1;
`endif
        end else if (w_term) begin
          CNT_EN      = 1'b0;
          w_state_nxt = S_FINAL;
        end else begin
          CNT_EN = 1'b1;
        end
      end
      S_FINAL: begin
        OUT_LOAD    = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        DONE = 1'b1;
        if (ACK) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ln_cordic_iter_ctrl.sv
// Scoreboard bench for ln_cordic_iter_ctrl with N_ITER=25 and 32.
// External counters are modelled here as plain clear/enable counters.
module tb_ln_cordic_iter_ctrl;

`ifdef LN_CORDIC_REPEAT_ITER_EN
  localparam bit REP = 1'b1;
  localparam int DONE25 = 30;
  localparam int DONE32 = 37;
`else
  localparam bit REP = 1'b0;
  localparam int DONE25 = 28;
  localparam int DONE32 = 35;
`endif

  typedef struct packed {
    logic [4:0] idx;
    logic       en;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       beg;
  logic       ack;
  logic       beg32;
  logic       ack32;

  logic [4:0] cnt;
  logic       cnt_en, cnt_rst, load_init, reg_en;
  logic       out_load, ready, done;
  logic [4:0] iter_idx;

  logic [4:0] cnt32;
  logic       cnt_en32, cnt_rst32, load_init32, reg_en32;
  logic       out_load32, ready32, done32;
  logic [4:0] iter_idx32;

  exp_t q[$];
  exp_t q32[$];
  int   tot = 0;
  int   bad = 0;
  int   max32 = 0;

  ln_cordic_iter_ctrl #(.W(5), .N_ITER(25)) u_dut (
    .CLK(clk), .RST(rst), .BEGIN(beg), .ACK(ack),
    .CNT_Y(cnt), .CNT_EN(cnt_en), .CNT_RST(cnt_rst),
    .ITER_IDX(iter_idx), .LOAD_INIT(load_init),
    .REG_EN(reg_en), .OUT_LOAD(out_load),
    .READY(ready), .DONE(done)
  );

  ln_cordic_iter_ctrl #(.W(5), .N_ITER(32)) u_dut32 (
    .CLK(clk), .RST(rst), .BEGIN(beg32), .ACK(ack32),
    .CNT_Y(cnt32), .CNT_EN(cnt_en32), .CNT_RST(cnt_rst32),
    .ITER_IDX(iter_idx32), .LOAD_INIT(load_init32),
    .REG_EN(reg_en32), .OUT_LOAD(out_load32),
    .READY(ready32), .DONE(done32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_rst) cnt <= 5'd0;
    else if (cnt_en) cnt <= cnt + 5'd1;
  end

  always @(posedge clk) begin
    if (cnt_rst32) cnt32 <= 5'd0;
    else if (cnt_en32) cnt32 <= cnt32 + 5'd1;
  end

  task automatic chk(input string nm, input int act, input int req);
    tot++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitors: one expected entry per REG_EN cycle.
  always @(negedge clk) begin
    if (reg_en === 1'b1) begin
      if (q.size() == 0) begin
        chk("iter_extra", int'(iter_idx), -1);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("iter_idx", int'(iter_idx), int'(x.idx));
        chk("cnt_en", int'(cnt_en), int'(x.en));
      end
    end
  end

  always @(negedge clk) begin
    if (reg_en32 === 1'b1) begin
      if (int'(iter_idx32) > max32) max32 = int'(iter_idx32);
      if (q32.size() == 0) begin
        chk("iter_extra32", int'(iter_idx32), -1);
      end else begin
        exp_t x;
        x = q32.pop_front();
        chk("iter_idx32", int'(iter_idx32), int'(x.idx));
        chk("cnt_en32", int'(cnt_en32), int'(x.en));
      end
    end
  end

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic push_seq(input int n, input bit to32);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      if (REP && (i == 4 || i == 13)) begin
        x.idx = 5'(i);
        x.en  = 1'b0;
        if (to32) q32.push_back(x);
        else      q.push_back(x);
      end
      x.idx = 5'(i);
      x.en  = (i != n - 1);
      if (to32) q32.push_back(x);
      else      q.push_back(x);
    end
  endtask

  task automatic run_job(input bit keep_begin, input bit ack_in_iter);
    int e;
    bit seen;
    beg = 1'b1;
    push_seq(25, 1'b0);
    @(posedge clk);
    e = 0;
    seen = 1'b0;
    while (!seen && e < 200) begin
      nstep();
      e++;
      if (!keep_begin) beg = 1'b0;
      ack = ack_in_iter && (e == 10);
      if (e == 1) chk("load_init", int'(load_init), 1);
      if (e == DONE25 - 1) chk("out_load", int'(out_load), 1);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("done_edge", e, DONE25);
    chk("ready_in_done", int'(ready), 0);
    repeat (3) nstep();
    chk("done_hold", int'(done), 1);
    chk("cnt_frozen", int'(cnt), 24);
    ack = 1'b1;
    beg = keep_begin;
    nstep();
    ack = 1'b0;
    chk("idle_ready", int'(ready), 1);
    chk("idle_done", int'(done), 0);
    chk("idle_cnt_rst", int'(cnt_rst), 1);
  endtask

  initial begin
    rst = 1'b1;
    beg = 1'b0;
    ack = 1'b0;
    beg32 = 1'b0;
    ack32 = 1'b0;
    repeat (2) @(posedge clk);
    nstep();
    chk("rst_ready", int'(ready), 1);
    chk("rst_cnt_rst", int'(cnt_rst), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_load_init", int'(load_init), 0);
    chk("rst_reg_en", int'(reg_en), 0);
    chk("rst_out_load", int'(out_load), 0);
    chk("rst_cnt", int'(cnt), 0);
    rst = 1'b0;
    nstep();

    // Plain job.
    run_job(1'b0, 1'b0);
    nstep();
    // BEGIN held through job and ACK, ACK pulsed mid-ITER.
    run_job(1'b1, 1'b1);
    // BEGIN still high: one IDLE cycle, then a new job.
    run_job(1'b0, 1'b0);
    repeat (3) nstep();
    chk("no_queued_begin", int'(ready), 1);

    // Reset in the middle of ITER at index 10.
    begin
      bit found;
      found = 1'b0;
      beg = 1'b1;
      push_seq(25, 1'b0);
      @(posedge clk);
      for (int k = 0; k < 100 && !found; k++) begin
        nstep();
        beg = 1'b0;
        if (reg_en === 1'b1 && iter_idx == 5'd10) found = 1'b1;
      end
      chk("reach_idx10", int'(found), 1);
      rst = 1'b1;
      q.delete();
      nstep();
      chk("mid_rst_ready", int'(ready), 1);
      chk("mid_rst_cnt_rst", int'(cnt_rst), 1);
      chk("mid_rst_reg_en", int'(reg_en), 0);
      nstep();
      chk("mid_rst_cnt", int'(cnt), 0);
      rst = 1'b0;
      nstep();
      run_job(1'b0, 1'b0);
    end

    // N_ITER = 2^W: terminate at all-ones without wrapping.
    begin
      int e;
      bit seen;
      beg32 = 1'b1;
      push_seq(32, 1'b1);
      @(posedge clk);
      e = 0;
      seen = 1'b0;
      while (!seen && e < 200) begin
        nstep();
        e++;
        beg32 = 1'b0;
        if (done32 === 1'b1) seen = 1'b1;
      end
      chk("done_edge32", e, DONE32);
      chk("max_idx32", max32, 31);
      chk("cnt32_frozen", int'(cnt32), 31);
      ack32 = 1'b1;
      nstep();
      ack32 = 1'b0;
      chk("idle_ready32", int'(ready32), 1);
    end

    repeat (2) nstep();
    chk("q_left", q.size(), 0);
    chk("q32_left", q32.size(), 0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
